// File: rtl/ts_clk_pkg.sv
// Shared phase constants, requester indices and parameter range check for the
// 28 MHz core clock domain.
package ts_clk_pkg;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam int unsigned NREQ_MIN = 2;
  localparam int unsigned NREQ_MAX = 8;

  localparam int unsigned REQ_VID = 0;
  localparam int unsigned REQ_CPU = 1;
  localparam int unsigned REQ_DMA = 2;

  function automatic bit nreq_ok(input int unsigned n);
    return (n >= NREQ_MIN) && (n <= NREQ_MAX);
  endfunction

endpackage

// File: rtl/ts_rr_arb.sv
// Combinational round-robin picker: searches from ptr+1 upward with wrap, so the
// last winner (ptr) has the lowest priority.
module ts_rr_arb #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  localparam logic [IW:0] NW = (IW + 1)'(N);

  logic [IW:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 1; k <= int'(N); k++) begin
      pos = {1'b0, ptr} + (IW + 1)'(k);
      if (pos >= NW) pos = pos - NW;
      if (!valid && req[pos[IW-1:0]]) begin
        valid              = 1'b1;
        gnt[pos[IW-1:0]]   = 1'b1;
        idx                = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ts_slot_sched.sv
// Phase-strobe generator and frame-slot arbiter: requester 0 has fixed priority,
// the rest share slots round-robin. All outputs registered from next-state values.
module ts_slot_sched
  import ts_clk_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic            f0,
  output logic            f1,
  output logic            h0,
  output logic            h1,
  output logic            c0,
  output logic            c1,
  output logic            c2,
  output logic            c3,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic [1:0]      cnt
);

  localparam int unsigned NRR = NREQ - 1;
  localparam int unsigned IW  = (NRR > 1) ? $clog2(NRR) : 1;
  localparam int unsigned PW  = $clog2(NREQ);

  if (!nreq_ok(NREQ)) begin : gen_nreq_bad
    $error("ts_slot_sched: NREQ out of range");
  end

  logic [1:0]      cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] grant_d, done_d;
  logic [NRR-1:0]  rr_gnt;
  logic [IW-1:0]   rr_idx, rr_ptr_sub;
  logic            rr_valid;

  // rr_ptr holds a requester index (1..NREQ-1); the picker works in 0-based space.
  assign rr_ptr_sub = IW'(rr_ptr_q - PW'(1));

  ts_rr_arb #(
    .N(NRR)
  ) u_rr_arb (
    .req  (req[NREQ-1:1]),
    .ptr  (rr_ptr_sub),
    .gnt  (rr_gnt),
    .idx  (rr_idx),
    .valid(rr_valid)
  );

  always_comb begin
    cnt_d    = en ? cnt_q + 2'd1 : cnt_q;
    grant_d  = grant;
    rr_ptr_d = rr_ptr_q;
    if (en && cnt_q == PH3) begin
      if (req[REQ_VID]) begin
        grant_d = NREQ'(1);
      end else if (rr_valid) begin
        grant_d  = {rr_gnt, 1'b0};
        rr_ptr_d = PW'(rr_idx) + PW'(1);
      end else begin
        grant_d = '0;
      end
    end
    done_d = (en && cnt_d == PH3) ? grant_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= PH3;
      rr_ptr_q <= PW'(NREQ - 1);
      cnt      <= PH0;
      grant    <= '0;
      done     <= '0;
      f0       <= 1'b0;
      f1       <= 1'b0;
      h0       <= 1'b0;
      h1       <= 1'b0;
      c0       <= 1'b0;
      c1       <= 1'b0;
      c2       <= 1'b0;
      c3       <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      grant    <= grant_d;
      done     <= done_d;
      if (en) cnt <= cnt_d;
      f0 <= en && (cnt_d == PH0 || cnt_d == PH2);
      f1 <= en && (cnt_d == PH1 || cnt_d == PH3);
      h0 <= en && (cnt_d == PH0 || cnt_d == PH1);
      h1 <= en && (cnt_d == PH2 || cnt_d == PH3);
      c0 <= en && (cnt_d == PH0);
      c1 <= en && (cnt_d == PH1);
      c2 <= en && (cnt_d == PH2);
      c3 <= en && (cnt_d == PH3);
    end
  end

endmodule

// File: tb/tb_ts_slot_sched.sv
// Scoreboard bench for ts_slot_sched (NREQ=3): stimulus pushes hand-computed
// output vectors, a monitor pops and compares them against the DUT.
module tb_ts_slot_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] req;
  logic       f0, f1, h0, h1, c0, c1, c2, c3;
  logic [2:0] grant, done;
  logic [1:0] cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  event chk_now;

  always #5 clk = ~clk;

  ts_slot_sched #(.NREQ(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .req  (req),
    .f0   (f0),
    .f1   (f1),
    .h0   (h0),
    .h1   (h1),
    .c0   (c0),
    .c1   (c1),
    .c2   (c2),
    .c3   (c3),
    .grant(grant),
    .done (done),
    .cnt  (cnt)
  );

  logic [15:0] act;
  assign act = {cnt, f0, f1, h0, h1, c0, c1, c2, c3, grant, done};

  // Expected vector: strobes follow the phase table, gated by 'on'.
  function automatic logic [15:0] ev(input logic [1:0] c, input logic on,
                                     input logic [2:0] g, input logic [2:0] d);
    logic ef0, ef1, eh0, eh1, ec0, ec1, ec2, ec3;
    ef0 = on && (c == 2'd0 || c == 2'd2);
    ef1 = on && (c == 2'd1 || c == 2'd3);
    eh0 = on && (c == 2'd0 || c == 2'd1);
    eh1 = on && (c == 2'd2 || c == 2'd3);
    ec0 = on && (c == 2'd0);
    ec1 = on && (c == 2'd1);
    ec2 = on && (c == 2'd2);
    ec3 = on && (c == 2'd3);
    return {c, ef0, ef1, eh0, eh1, ec0, ec1, ec2, ec3, g, d};
  endfunction

  task automatic push(input logic [15:0] v, input string nm);
    exp_t e;
    e.v    = v;
    e.name = nm;
    q.push_back(e);
  endtask

  // Drive inputs mid-cycle, then record what the next edge must produce.
  task automatic step(input logic r, input logic e, input logic [2:0] rq,
                      input logic [1:0] c, input logic on,
                      input logic [2:0] g, input logic [2:0] d, input string nm);
    @(negedge clk);
    #1;
    rst = r;
    en  = e;
    req = rq;
    @(posedge clk);
    push(ev(c, on, g, d), nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      #0;
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got cnt/f0f1/h0h1/c0-3/grant/done=%b, want %b", e.name, act, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    en  = 1'b1;
    req = 3'b000;
    @(posedge clk);
    push(ev(2'd0, 1'b0, 3'b000, 3'b000), "reset");

    // Free-running frame with no requests
    step(0, 1, 3'b000, 2'd0, 1, 3'b000, 3'b000, "idle_c0");
    step(0, 1, 3'b000, 2'd1, 1, 3'b000, 3'b000, "idle_c1");
    step(0, 1, 3'b000, 2'd2, 1, 3'b000, 3'b000, "idle_c2");
    step(0, 1, 3'b000, 2'd3, 1, 3'b000, 3'b000, "idle_c3");
    step(0, 1, 3'b000, 2'd0, 1, 3'b000, 3'b000, "idle2_c0");
    step(0, 1, 3'b000, 2'd1, 1, 3'b000, 3'b000, "idle2_c1");
    step(0, 1, 3'b000, 2'd2, 1, 3'b000, 3'b000, "idle2_c2");
    step(0, 1, 3'b000, 2'd3, 1, 3'b000, 3'b000, "idle2_c3");

    // Round-robin between requesters 1 and 2
    step(0, 1, 3'b110, 2'd0, 1, 3'b010, 3'b000, "rr1_g");
    step(0, 1, 3'b110, 2'd1, 1, 3'b010, 3'b000, "rr1_c1");
    step(0, 1, 3'b110, 2'd2, 1, 3'b010, 3'b000, "rr1_c2");
    step(0, 1, 3'b110, 2'd3, 1, 3'b010, 3'b010, "rr1_done");
    step(0, 1, 3'b110, 2'd0, 1, 3'b100, 3'b000, "rr2_g");
    step(0, 1, 3'b110, 2'd1, 1, 3'b100, 3'b000, "rr2_c1");
    step(0, 1, 3'b110, 2'd2, 1, 3'b100, 3'b000, "rr2_c2");
    step(0, 1, 3'b110, 2'd3, 1, 3'b100, 3'b100, "rr2_done");
    step(0, 1, 3'b110, 2'd0, 1, 3'b010, 3'b000, "rr3_g");
    step(0, 1, 3'b110, 2'd1, 1, 3'b010, 3'b000, "rr3_c1");
    step(0, 1, 3'b110, 2'd2, 1, 3'b010, 3'b000, "rr3_c2");
    step(0, 1, 3'b110, 2'd3, 1, 3'b010, 3'b010, "rr3_done");

    // Video requester overrides; rr_ptr must stay on requester 1
    step(0, 1, 3'b111, 2'd0, 1, 3'b001, 3'b000, "vid1_g");
    step(0, 1, 3'b111, 2'd1, 1, 3'b001, 3'b000, "vid1_c1");
    step(0, 1, 3'b111, 2'd2, 1, 3'b001, 3'b000, "vid1_c2");
    step(0, 1, 3'b111, 2'd3, 1, 3'b001, 3'b001, "vid1_done");
    step(0, 1, 3'b111, 2'd0, 1, 3'b001, 3'b000, "vid2_g");
    step(0, 1, 3'b111, 2'd1, 1, 3'b001, 3'b000, "vid2_c1");
    step(0, 1, 3'b111, 2'd2, 1, 3'b001, 3'b000, "vid2_c2");
    step(0, 1, 3'b111, 2'd3, 1, 3'b001, 3'b001, "vid2_done");
    step(0, 1, 3'b110, 2'd0, 1, 3'b100, 3'b000, "ptr_kept_g");
    step(0, 1, 3'b110, 2'd1, 1, 3'b100, 3'b000, "ptr_kept_c1");
    step(0, 1, 3'b110, 2'd2, 1, 3'b100, 3'b000, "ptr_kept_c2");
    step(0, 1, 3'b110, 2'd3, 1, 3'b100, 3'b100, "ptr_kept_done");

    // Run enable dropped for 5 clocks at cnt=1
    step(0, 1, 3'b010, 2'd0, 1, 3'b010, 3'b000, "en_g");
    step(0, 1, 3'b010, 2'd1, 1, 3'b010, 3'b000, "en_c1");
    for (int i = 0; i < 5; i++) step(0, 0, 3'b010, 2'd1, 0, 3'b010, 3'b000, "en_off");
    step(0, 1, 3'b010, 2'd2, 1, 3'b010, 3'b000, "en_resume_c2");
    step(0, 1, 3'b010, 2'd3, 1, 3'b010, 3'b010, "en_resume_done");
    step(0, 1, 3'b010, 2'd0, 1, 3'b010, 3'b000, "rst_pre_g");
    step(0, 1, 3'b010, 2'd1, 1, 3'b010, 3'b000, "rst_pre_c1");
    step(0, 1, 3'b010, 2'd2, 1, 3'b010, 3'b000, "rst_pre_c2");

    // Asynchronous reset mid-frame at cnt=2
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    push(ev(2'd0, 1'b0, 3'b000, 3'b000), "rst_async");
    ->chk_now;
    step(1, 1, 3'b100, 2'd0, 0, 3'b000, 3'b000, "rst_hold");
    step(0, 1, 3'b100, 2'd0, 1, 3'b100, 3'b000, "rst_rel_g");
    // Requester 2 drops mid-frame; frame still completes with done
    step(0, 1, 3'b000, 2'd1, 1, 3'b100, 3'b000, "drop_c1");
    step(0, 1, 3'b000, 2'd2, 1, 3'b100, 3'b000, "drop_c2");
    step(0, 1, 3'b000, 2'd3, 1, 3'b100, 3'b100, "drop_done");

    // Request raised on the boundary edge: served one frame later
    step(0, 1, 3'b000, 2'd0, 1, 3'b000, 3'b000, "late_idle_g");
    #1;
    req = 3'b100;
    step(0, 1, 3'b100, 2'd1, 1, 3'b000, 3'b000, "late_c1");
    step(0, 1, 3'b100, 2'd2, 1, 3'b000, 3'b000, "late_c2");
    step(0, 1, 3'b100, 2'd3, 1, 3'b000, 3'b000, "late_c3");
    step(0, 1, 3'b100, 2'd0, 1, 3'b100, 3'b000, "late_g");
    step(0, 1, 3'b100, 2'd1, 1, 3'b100, 3'b000, "late_g_c1");
    step(0, 1, 3'b100, 2'd2, 1, 3'b100, 3'b000, "late_g_c2");
    step(0, 1, 3'b100, 2'd3, 1, 3'b100, 3'b100, "late_done");

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_slot_sched.md
# ts_slot_sched

Phase-strobe generator and slot arbiter for the 28 MHz core clock domain. A 2-bit phase counter sets the shared 4-phase frame that every clocked part uses: f0/f1 at 14 MHz, h0/h1 and c0..c3 at 7 MHz. At each frame boundary the block grants the next whole 4-clock frame (one memory/bus slot) to one of NREQ requesters. Requester 0 (video fetch) has fixed top priority; the other requesters share the remaining slots round-robin.

## Interface
- NREQ, 3: number of requesters, 2..8; index 0 is the fixed-priority requester.
- clk  in  1  28 MHz core clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run enable. While 0, the phase counter and grant hold, and all strobes are 0.
- req  in  NREQ  level request per requester. Must stay asserted until its `done` pulse.
- f0, f1  out  1  14 MHz strobes, phase 0 / 180.
- h0, h1  out  1  7 MHz half strobes, phase 0 / 180.
- c0, c1, c2, c3  out  1  7 MHz quarter strobes, phase 0 / 90 / 180 / 270.
- grant  out  NREQ  one-hot or zero; owner of the current frame.
- done  out  NREQ  one-clock pulse on the owner's bit in the last clock (cnt=3) of its frame.
- cnt  out  2  current phase index, for debug and alignment.

## Operation
- The phase counter cnt advances 0→1→2→3→0 on every clk edge while en=1.
- All outputs are registered. Each output is decoded from the next counter value, so it is aligned with cnt and has no combinational path from req or en.
- Strobe decode, with en=1:
  - f0 = (cnt is 0 or 2); f1 = (cnt is 1 or 3).
  - h0 = (cnt is 0 or 1); h1 = (cnt is 2 or 3).
  - c0 = (cnt=0); c1 = (cnt=1); c2 = (cnt=2); c3 = (cnt=3).
- Arbitration happens on the edge where cnt goes 3→0 (en=1), using req as sampled on that edge:
  - If req[0] is set, grant = 1<<0.
  - Otherwise, the first asserted req[i] for i in 1..NREQ-1 gets the grant. The search starts at rr_ptr+1 and wraps from NREQ-1 back to 1.
  - If no request is set, grant = 0.
- rr_ptr is set to the granted index only when that index is ≥1. A requester 0 grant or an idle frame leaves rr_ptr unchanged.
- grant is constant for the whole frame (cnt 0..3). Arbitration does not change it mid-frame.
- done[i] = grant[i] during the clock where cnt=3.
- A requester that keeps req asserted after its done pulse competes again at the next boundary.
- Requester 0 can starve the others by design; video bandwidth is bounded by the system.
- en=0 at any point:
  - cnt, grant and rr_ptr freeze.
  - Strobes and done are 0.
  - On the first edge after en returns to 1, output resumes from the frozen cnt+1.

## Timing
- Reset values: cnt=3 (internal, so the first frame after release starts cleanly), outputs cnt=0, all strobes 0, grant=0, done=0, rr_ptr=NREQ-1.
- First edge after rst deasserts (en=1):
  - cnt=0, with c0=f0=h0=1.
  - The first arbitration happens on this edge.
- Request-to-grant latency is 1 to 4 clocks: a req is sampled at the next 3→0 boundary, and grant is visible in the cnt=0 clock.
- Frame length is exactly 4 clocks. The done pulse lasts 1 clock.
- When req drops mid-frame, the frame still completes and done still pulses. The requester ignores it.
- When a request is raised on the boundary edge itself, the arbiter sees the old sampled value. The request is served at the following boundary.
- Reset asserted mid-frame:
  - All outputs clear asynchronously.
  - The in-flight slot is aborted and no done pulse is issued.
- Invariant: exactly one of c0..c3 is high whenever en=1 and rst=0.

## Structure
- Shared package ts_clk_pkg holds:
  - phase constants PH0..PH3 (2-bit);
  - the NREQ range check;
  - the requester index constants REQ_VID=0, REQ_CPU=1, REQ_DMA=2.
- Sub-module ts_rr_arb (NREQ-1 wide round-robin picker: req and pointer in, one-hot and index out) is combinational. The top-level block adds the fixed-priority override and the registers.

## Test plan
- Reset release with en=1, req=0:
  - c0..c3 cycle 1000,0100,0010,0001 with period 4;
  - f0 toggles every clock;
  - h0 is high for 2 clocks out of 4;
  - grant stays 0.
- NREQ=3, req=3'b110 held: grant alternates 010,100,010 on successive frames, and done pulses at cnt=3 of each.
- req=3'b111 held: grant=001 every frame; rr_ptr does not change; done[0] pulses every 4 clocks.
- en=0 for 5 clocks at cnt=1:
  - strobes are 0 and grant is held;
  - after en=1, the next cnt is 2 and the frame completes with one done pulse.
- rst asserted at cnt=2 with grant=010: all outputs are 0 immediately with no done pulse; after release, the first frame grants again from req.
- req[2] raised in the same edge as 3→0: not granted that frame, granted in the next one (latency 4 clocks).
